// File: rtl/jstk_pkg.sv
// Shared encodings for the joystick poll controller: directions, FSM states,
// decoded sample layout and the SPI command byte.
package jstk_pkg;

  localparam int unsigned AXIS_W  = 10;
  localparam int unsigned DIR_W   = 3;
  localparam int unsigned BTN_W   = 3;
  localparam int unsigned FRAME_W = 40;
  localparam int unsigned LED_W   = 2;
  localparam int unsigned CMD_W   = 8;

  localparam logic [5:0] CMD_PREFIX = 6'b100000;

  typedef enum logic [DIR_W-1:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_RIGHT = 3'd3,
    DIR_LEFT  = 3'd4
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DECODE = 2'd3
  } state_e;

  typedef struct packed {
    logic [AXIS_W-1:0] y;
    logic [AXIS_W-1:0] x;
    logic [BTN_W-1:0]  btn;
  } sample_t;

  function automatic logic [CMD_W-1:0] cmd_byte(input logic [LED_W-1:0] led);
    return {CMD_PREFIX, led};
  endfunction

endpackage

// File: rtl/jstk_dir_filter.sv
// Direction classifier with hysteresis on the committed direction and an
// N-sample debounce before a new direction is committed.
module jstk_dir_filter
  import jstk_pkg::*;
#(
  parameter int unsigned HI_TH    = 800,
  parameter int unsigned LO_TH    = 200,
  parameter int unsigned HYST     = 50,
  parameter int unsigned STABLE_N = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  input  logic [AXIS_W-1:0] x,
  input  logic [AXIS_W-1:0] y,
  output logic [DIR_W-1:0]  dir,
  output logic              dir_valid
);

  localparam int unsigned CNT_W = $clog2(STABLE_N + 1);
  localparam logic [AXIS_W-1:0] HI     = AXIS_W'(HI_TH);
  localparam logic [AXIS_W-1:0] LO     = AXIS_W'(LO_TH);
  localparam logic [AXIS_W-1:0] HI_REL = AXIS_W'(HI_TH - HYST);
  localparam logic [AXIS_W-1:0] LO_REL = AXIS_W'(LO_TH + HYST);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_N);

  dir_e             dir_q;
  dir_e             prev_q;
  dir_e             raw_c;
  dir_e             cand_c;
  logic             hold_c;
  logic             commit_c;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt_c;

  assign dir = dir_q;

  // Raw classification, first match wins, strict unsigned compares
  always_comb begin
    raw_c = DIR_NONE;
    if (y > HI)      raw_c = DIR_UP;
    else if (y < LO) raw_c = DIR_DOWN;
    else if (x > HI) raw_c = DIR_RIGHT;
    else if (x < LO) raw_c = DIR_LEFT;
  end

  // Committed direction survives while its axis stays past the relaxed bound
  always_comb begin
    hold_c = 1'b0;
    case (dir_q)
      DIR_UP:    hold_c = (y > HI_REL);
      DIR_DOWN:  hold_c = (y < LO_REL);
      DIR_RIGHT: hold_c = (x > HI_REL);
      DIR_LEFT:  hold_c = (x < LO_REL);
      default:   hold_c = 1'b0;
    endcase
    cand_c = hold_c ? dir_q : raw_c;
  end

  always_comb begin
    cnt_nxt_c = CNT_W'(1);
    if (cand_c == dir_q)
      cnt_nxt_c = '0;
    else if (cand_c == prev_q)
      cnt_nxt_c = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
    commit_c = (cand_c != dir_q) && (cnt_nxt_c == CNT_MAX);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dir_q     <= DIR_NONE;
      prev_q    <= DIR_NONE;
      cnt_q     <= '0;
      dir_valid <= 1'b0;
    end else begin
      dir_valid <= 1'b0;
      if (en) begin
        prev_q <= cand_c;
        if (commit_c) begin
          dir_q     <= cand_c;
          dir_valid <= 1'b1;
          cnt_q     <= '0;
        end else begin
          cnt_q <= cnt_nxt_c;
        end
      end
    end
  end

endmodule

// File: rtl/jstk_poll_ctrl.sv
// Periodic joystick poller: requests a 5-byte SPI frame every POLL_DIV cycles,
// guards the transfer with a timeout and decodes axes, buttons and direction.
module jstk_poll_ctrl
  import jstk_pkg::*;
#(
  parameter int unsigned POLL_DIV = 2_000_000,
  parameter int unsigned TIMEOUT  = 200_000,
  parameter int unsigned HI_TH    = 800,
  parameter int unsigned LO_TH    = 200,
  parameter int unsigned HYST     = 50,
  parameter int unsigned STABLE_N = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [LED_W-1:0]   led_req,
  input  logic               frame_done,
  input  logic [FRAME_W-1:0] jstk_data,
  output logic               snd_rec,
  output logic [CMD_W-1:0]   snd_data,
  output logic [AXIS_W-1:0]  x_pos,
  output logic [AXIS_W-1:0]  y_pos,
  output logic [BTN_W-1:0]   btn,
  output logic [DIR_W-1:0]   dir,
  output logic               dir_valid,
  output logic               timeout_err
);

  localparam int unsigned PCNT_W = $clog2(POLL_DIV + 1);
  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q;
  state_e            state_nxt;
  logic [PCNT_W-1:0] poll_cnt_q;
  logic [TCNT_W-1:0] tmo_cnt_q;
  logic              tick_c;
  logic              tmo_hit_c;
  logic              in_wait_c;
  sample_t           smp_c;
  sample_t           frame_q;
  logic              unused_frame_bits;

  assign snd_data  = cmd_byte(led_req);
  assign tick_c    = (poll_cnt_q == PCNT_W'(POLL_DIV - 1));
  assign tmo_hit_c = (tmo_cnt_q == TCNT_W'(TIMEOUT - 1));
  assign in_wait_c = (state_q == ST_WAIT);

  always_comb begin
    smp_c.x   = {jstk_data[9:8], jstk_data[23:16]};
    smp_c.y   = {jstk_data[25:24], jstk_data[39:32]};
    smp_c.btn = {jstk_data[1], jstk_data[2], jstk_data[0]};
  end

  assign unused_frame_bits = ^{jstk_data[31:26], jstk_data[15:10], jstk_data[7:3]};

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  // Ticks arriving outside IDLE are dropped, never queued
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:   if (tick_c) state_nxt = ST_REQ;
      ST_REQ:    state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (frame_done)     state_nxt = ST_DECODE;
        else if (tmo_hit_c) state_nxt = ST_IDLE;
      end
      ST_DECODE: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      poll_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      frame_q     <= '0;
      snd_rec     <= 1'b0;
      x_pos       <= '0;
      y_pos       <= '0;
      btn         <= '0;
      timeout_err <= 1'b0;
    end else begin
      poll_cnt_q <= tick_c ? '0 : poll_cnt_q + PCNT_W'(1);
      snd_rec    <= (state_nxt == ST_REQ);
      tmo_cnt_q  <= in_wait_c ? tmo_cnt_q + TCNT_W'(1) : '0;
      if (in_wait_c && frame_done)
        frame_q <= smp_c;
      if (in_wait_c && !frame_done && tmo_hit_c)
        timeout_err <= 1'b1;
      if (state_q == ST_DECODE) begin
        x_pos <= frame_q.x;
        y_pos <= frame_q.y;
        btn   <= frame_q.btn;
      end
    end
  end

  jstk_dir_filter #(
    .HI_TH   (HI_TH),
    .LO_TH   (LO_TH),
    .HYST    (HYST),
    .STABLE_N(STABLE_N)
  ) u_dir_filter (
    .CLK      (CLK),
    .RST      (RST),
    .en       (state_q == ST_DECODE),
    .x        (frame_q.x),
    .y        (frame_q.y),
    .dir      (dir),
    .dir_valid(dir_valid)
  );

endmodule

// File: tb/tb_jstk_poll_ctrl.sv
// Directed bench for jstk_poll_ctrl with POLL_DIV=100 and TIMEOUT=50.
module tb_jstk_poll_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  led_req;
  logic        frame_done;
  logic [39:0] jstk_data;
  logic        snd_rec;
  logic [7:0]  snd_data;
  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  logic [2:0]  btn;
  logic [2:0]  dir;
  logic        dir_valid;
  logic        timeout_err;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int dv_pulses   = 0;
  int rise_cyc    = 0;
  int rel_cyc     = 0;

  jstk_poll_ctrl #(.POLL_DIV(100), .TIMEOUT(50)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .led_req    (led_req),
    .frame_done (frame_done),
    .jstk_data  (jstk_data),
    .snd_rec    (snd_rec),
    .snd_data   (snd_data),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .btn        (btn),
    .dir        (dir),
    .dir_valid  (dir_valid),
    .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (dir_valid) dv_pulses <= dv_pulses + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [39:0] mk_frame(input int x, input int y, input int b);
    logic [39:0] f;
    logic [9:0]  xv;
    logic [9:0]  yv;
    logic [2:0]  bv;
    xv = 10'(x);
    yv = 10'(y);
    bv = 3'(b);
    f = '1;
    f[39:32] = yv[7:0];
    f[25:24] = yv[9:8];
    f[23:16] = xv[7:0];
    f[9:8]   = xv[9:8];
    f[1]     = bv[2];
    f[2]     = bv[1];
    f[0]     = bv[0];
    return f;
  endfunction

  // Step until snd_rec is seen; an exhausted budget is a miscompare
  task automatic wait_req(input int budget);
    int n;
    n = 0;
    while (!snd_rec && n < budget) begin
      step();
      n++;
    end
    if (!snd_rec) check("req_seen", 0, 1);
    rise_cyc = cyc;
  endtask

  task automatic next_req();
    int prev;
    prev = rise_cyc;
    wait_req(150);
    check("poll_period", rise_cyc - prev, 100);
  endtask

  // Called at the snd_rec rise; answers 10 cycles later, checks 2-cycle latency
  task automatic serve(input int x, input int y, input int b, input int exp_dir, input int exp_dv);
    step();
    check("snd_rec_width", int'(snd_rec), 0);
    repeat (9) step();
    jstk_data  = mk_frame(x, y, b);
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    jstk_data  = '0;
    check("dv_latency1", int'(dir_valid), 0);
    step();
    check("x_pos", int'(x_pos), x);
    check("y_pos", int'(y_pos), y);
    check("btn", int'(btn), b);
    check("dir", int'(dir), exp_dir);
    check("dir_valid", int'(dir_valid), exp_dv);
    step();
    check("dv_width", int'(dir_valid), 0);
  endtask

  task automatic poll(input int x, input int y, input int b, input int exp_dir, input int exp_dv);
    serve(x, y, b, exp_dir, exp_dv);
    next_req();
  endtask

  initial begin
    RST        = 1'b1;
    led_req    = 2'b10;
    frame_done = 1'b0;
    jstk_data  = '0;
    repeat (3) step();

    check("rst_snd_rec", int'(snd_rec), 0);
    check("rst_x_pos", int'(x_pos), 0);
    check("rst_y_pos", int'(y_pos), 0);
    check("rst_btn", int'(btn), 0);
    check("rst_dir", int'(dir), 0);
    check("rst_dir_valid", int'(dir_valid), 0);
    check("rst_timeout_err", int'(timeout_err), 0);
    check("snd_data_10", int'(snd_data), 'h82);
    led_req = 2'b01;
    #1;
    check("snd_data_01", int'(snd_data), 'h81);

    RST     = 1'b0;
    rel_cyc = cyc;
    wait_req(150);
    check("rst_to_req", rise_cyc - rel_cyc, 100);

    // Exactly at the thresholds: strict compares give NONE
    poll(200, 800, 0, 0, 0);

    // Three UP samples commit on the third
    poll(512, 900, 5, 0, 0);
    poll(512, 900, 5, 0, 0);
    poll(512, 900, 5, 1, 1);
    check("dv_count_up", dv_pulses, 1);

    // 760 is above the relaxed bound 750, so UP holds
    repeat (5) poll(512, 760, 3, 1, 0);
    check("dv_count_hyst", dv_pulses, 1);

    poll(512, 740, 3, 1, 0);
    poll(512, 740, 3, 1, 0);
    poll(512, 740, 3, 0, 1);
    check("dv_count_none", dv_pulses, 2);

    // Alternating candidates never build a count
    poll(900, 512, 6, 0, 0);
    poll(100, 512, 6, 0, 0);
    poll(900, 512, 6, 0, 0);
    poll(100, 512, 6, 0, 0);
    check("dv_count_alt", dv_pulses, 2);

    // Previous LEFT candidate carries count 1, so two more LEFT samples commit
    serve(100, 512, 2, 0, 0);
    jstk_data  = mk_frame(5, 5, 7);
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    jstk_data  = '0;
    repeat (3) step();
    check("idle_frame_x", int'(x_pos), 100);
    check("idle_frame_y", int'(y_pos), 512);
    check("idle_frame_btn", int'(btn), 2);
    check("idle_frame_dir", int'(dir), 0);
    next_req();
    poll(100, 512, 2, 4, 1);
    check("dv_count_left", dv_pulses, 3);

    // No response: timeout on the 50th WAIT cycle, outputs untouched
    repeat (50) step();
    check("tmo_early", int'(timeout_err), 0);
    step();
    check("tmo_set", int'(timeout_err), 1);
    check("tmo_x_pos", int'(x_pos), 100);
    check("tmo_y_pos", int'(y_pos), 512);
    check("tmo_dir", int'(dir), 4);
    next_req();

    poll(100, 512, 1, 4, 0);
    check("tmo_sticky", int'(timeout_err), 1);

    // Reset in WAIT, then the stale frame_done arrives
    repeat (5) step();
    RST = 1'b1;
    step();
    check("rstw_snd_rec", int'(snd_rec), 0);
    check("rstw_x_pos", int'(x_pos), 0);
    check("rstw_dir", int'(dir), 0);
    check("rstw_timeout_err", int'(timeout_err), 0);
    RST        = 1'b0;
    rel_cyc    = cyc;
    jstk_data  = mk_frame(900, 900, 7);
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    jstk_data  = '0;
    repeat (3) step();
    check("stale_x_pos", int'(x_pos), 0);
    check("stale_y_pos", int'(y_pos), 0);
    check("stale_btn", int'(btn), 0);
    check("stale_dir", int'(dir), 0);
    check("stale_dir_valid", int'(dir_valid), 0);
    check("stale_timeout_err", int'(timeout_err), 0);
    check("dv_count_final", dv_pulses, 3);
    wait_req(150);
    check("rstw_to_req", rise_cyc - rel_cyc, 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
